// File: rtl/add6_arbiter.sv
// Two-port round-robin arbiter sharing one registered 6-bit adder with carry.
// Optional multi-word carry chaining is enabled with `define ADD6_ARBITER_CHAIN_EN.
module add6_arbiter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         req1_ready,
`ifdef ADD6_ARBITER_CHAIN_EN
  input  logic         req0_chain,
  input  logic         req1_chain,
`endif
  output logic         res_valid,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_id,
  input  logic         res_ready
);

  typedef enum logic {LAST0 = 1'b0, LAST1 = 1'b1} ptr_t;

  ptr_t         ptr_q, ptr_d;
  logic         free, grant0, grant1, accept, winner;
  logic [W-1:0] op_a, op_b;
  logic         op_cin;
  logic [W:0]   total;

`ifdef ADD6_ARBITER_CHAIN_EN
  logic lock_q, lock_id_q, carry_q, chain_w;
`endif

  assign free = ~res_valid | res_ready;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef ADD6_ARBITER_CHAIN_EN
    if (lock_q) begin
      // An open chain owns the adder; the other port starves until it ends.
      grant0 = req0_valid & ~lock_id_q;
      grant1 = req1_valid &  lock_id_q;
    end else
`endif
    begin
      if (req0_valid && req1_valid) begin
        grant0 = (ptr_q == LAST1);
        grant1 = (ptr_q == LAST0);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = free & grant0;
  assign req1_ready = free & grant1;
  assign accept     = req0_ready | req1_ready;
  assign winner     = req1_ready;

  always_comb begin
    op_a   = winner ? req1_a   : req0_a;
    op_b   = winner ? req1_b   : req0_b;
    op_cin = winner ? req1_cin : req0_cin;
`ifdef ADD6_ARBITER_CHAIN_EN
    if (lock_q) op_cin = carry_q;
`endif
  end

  assign total = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin};

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = winner ? LAST1 : LAST0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= LAST1;
    else     ptr_q <= ptr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= 1'b0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_sum   <= total[W-1:0];
      res_cout  <= total[W];
      res_id    <= winner;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ADD6_ARBITER_CHAIN_EN
  assign chain_w = winner ? req1_chain : req0_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      carry_q   <= 1'b0;
    end else if (accept) begin
      lock_q    <= chain_w;
      lock_id_q <= winner;
      carry_q   <= chain_w & total[W];
    end
  end
`endif

endmodule

// File: tb/tb_add6_arbiter.sv
// Self-checking bench for add6_arbiter: directed vector table, reset and
// chain sequences, then randomized traffic against a behavioural model.
module tb_add6_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_cin, req0_ready;
  logic [5:0] req0_a, req0_b;
  logic       req1_valid, req1_cin, req1_ready;
  logic [5:0] req1_a, req1_b;
  logic       req0_chain, req1_chain;
  logic       res_valid, res_cout, res_id, res_ready;
  logic [5:0] res_sum;

  int n_cmp = 0;
  int n_bad = 0;

  add6_arbiter #(.W(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_ready(req1_ready),
`ifdef ADD6_ARBITER_CHAIN_EN
    .req0_chain(req0_chain), .req1_chain(req1_chain),
`endif
    .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v0; int a0; int b0; bit c0;
    bit v1; int a1; int b1; bit c1;
    bit rr;
    bit er0; bit er1;
    bit ev; int es; bit ec; bit eid;
  } vec_t;

  vec_t tv[11];

  function automatic vec_t mk(bit v0, int a0, int b0, bit c0, bit v1, int a1, int b1, bit c1,
                              bit rr, bit er0, bit er1, bit ev, int es, bit ec, bit eid);
    vec_t r;
    r.v0 = v0; r.a0 = a0; r.b0 = b0; r.c0 = c0;
    r.v1 = v1; r.a1 = a1; r.b1 = b1; r.c1 = c1;
    r.rr = rr; r.er0 = er0; r.er1 = er1;
    r.ev = ev; r.es = es; r.ec = ec; r.eid = eid;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v0, input int a0, input int b0, input bit c0,
                       input bit v1, input int a1, input int b1, input bit c1,
                       input bit rr, input bit ch0, input bit ch1);
    req0_valid = v0; req0_a = 6'(a0); req0_b = 6'(b0); req0_cin = c0;
    req1_valid = v1; req1_a = 6'(a1); req1_b = 6'(b1); req1_cin = c1;
    res_ready = rr; req0_chain = ch0; req1_chain = ch1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive inputs, check readys combinationally, clock once, check the result.
  task automatic step(input string tag, input bit v0, input int a0, input int b0, input bit c0,
                      input bit v1, input int a1, input int b1, input bit c1, input bit rr,
                      input bit ch0, input bit ch1, input bit er0, input bit er1,
                      input bit ev, input int es, input bit ec, input bit eid);
    drive(v0, a0, b0, c0, v1, a1, b1, c1, rr, ch0, ch1);
    #1;
    chk({tag, ".req0_ready"}, int'(req0_ready), int'(er0));
    chk({tag, ".req1_ready"}, int'(req1_ready), int'(er1));
    @(posedge clk);
    #1;
    chk({tag, ".res_valid"}, int'(res_valid), int'(ev));
    if (ev) begin
      chk({tag, ".res_sum"},  int'(res_sum),  es);
      chk({tag, ".res_cout"}, int'(res_cout), int'(ec));
      chk({tag, ".res_id"},   int'(res_id),   int'(eid));
    end
  endtask

  // Behavioural reference: result register + "last winner" pointer.
  bit m_valid, m_cout, m_id;
  int m_sum, m_last;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.res_valid", int'(res_valid), 0);
    chk("rst.res_sum", int'(res_sum), 0);
    chk("rst.res_cout", int'(res_cout), 0);
    chk("rst.res_id", int'(res_id), 0);
    chk("rst.req0_ready", int'(req0_ready), 0);
    chk("rst.req1_ready", int'(req1_ready), 0);
    rst = 1'b0;

    //            v0 a0 b0 c0  v1 a1 b1 c1  rr r0 r1  ev sum co id
    tv[0]  = mk(0, 0, 0, 0,  0, 0, 0, 0,   1, 0, 0,  0, 0, 0, 0);
    tv[1]  = mk(1, 5, 9, 1,  0, 0, 0, 0,   1, 1, 0,  1, 15, 0, 0);
    tv[2]  = mk(1, 1, 2, 0,  1, 10, 20, 1, 1, 0, 1,  1, 31, 0, 1);
    tv[3]  = mk(1, 1, 2, 0,  1, 10, 20, 1, 1, 1, 0,  1, 3, 0, 0);
    tv[4]  = mk(1, 1, 2, 0,  1, 10, 20, 1, 1, 0, 1,  1, 31, 0, 1);
    tv[5]  = mk(0, 0, 0, 0,  1, 63, 63, 1, 1, 0, 1,  1, 63, 1, 1);
    tv[6]  = mk(1, 7, 0, 0,  0, 0, 0, 0,   0, 0, 0,  1, 63, 1, 1);
    tv[7]  = mk(1, 9, 9, 1,  1, 2, 2, 0,   0, 0, 0,  1, 63, 1, 1);
    tv[8]  = mk(1, 7, 0, 0,  0, 0, 0, 0,   0, 0, 0,  1, 63, 1, 1);
    tv[9]  = mk(1, 7, 0, 0,  0, 0, 0, 0,   1, 1, 0,  1, 7, 0, 0);
    tv[10] = mk(0, 0, 0, 0,  0, 0, 0, 0,   1, 0, 0,  0, 0, 0, 0);

    for (int i = 0; i < 11; i++)
      step($sformatf("vec%0d", i), tv[i].v0, tv[i].a0, tv[i].b0, tv[i].c0,
           tv[i].v1, tv[i].a1, tv[i].b1, tv[i].c1, tv[i].rr, 1'b0, 1'b0,
           tv[i].er0, tv[i].er1, tv[i].ev, tv[i].es, tv[i].ec, tv[i].eid);

    // Reset mid-operation: pending result discarded, pointer back to port 0 first.
    step("mid.acc", 1, 2, 3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 5, 0, 0);
    rst = 1'b1;
    drive(1, 4, 4, 0, 1, 8, 8, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("mid.res_valid", int'(res_valid), 0);
    chk("mid.res_sum", int'(res_sum), 0);
    rst = 1'b0;
    step("mid.after", 1, 4, 4, 0, 1, 8, 8, 0, 1, 0, 0, 1, 0, 1, 8, 0, 0);

`ifdef ADD6_ARBITER_CHAIN_EN
    do_reset();
    step("chain.w0", 1, 63, 1, 0, 1, 3, 3, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0);
    step("chain.w1", 1, 0, 0, 0, 1, 3, 3, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
    step("chain.p1", 0, 0, 0, 0, 1, 3, 3, 0, 1, 0, 0, 0, 1, 1, 6, 0, 1);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    m_valid = 0; m_sum = 0; m_cout = 0; m_id = 0; m_last = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit v0, v1, c0, c1, rr, free;
      int a0, b0, a1, b1, win, tot;
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      a0 = $urandom_range(0, 63); b0 = $urandom_range(0, 63); c0 = 1'($urandom);
      a1 = $urandom_range(0, 63); b1 = $urandom_range(0, 63); c1 = 1'($urandom);
      rr = ($urandom_range(0, 9) < 7);
      drive(v0, a0, b0, c0, v1, a1, b1, c1, rr, 0, 0);
      free = !m_valid || rr;
      win = -1;
      if (free) begin
        if (v0 && v1) win = 1 - m_last;
        else if (v0)  win = 0;
        else if (v1)  win = 1;
      end
      #1;
      chk("rnd.req0_ready", int'(req0_ready), int'(win == 0));
      chk("rnd.req1_ready", int'(req1_ready), int'(win == 1));
      if (win >= 0) begin
        tot = (win == 0) ? a0 + b0 + int'(c0) : a1 + b1 + int'(c1);
        m_sum = tot % 64; m_cout = (tot >= 64); m_id = (win == 1);
        m_valid = 1; m_last = win;
      end else if (m_valid && rr) begin
        m_valid = 0;
      end
      @(posedge clk);
      #1;
      chk("rnd.res_valid", int'(res_valid), int'(m_valid));
      if (m_valid) begin
        chk("rnd.res_sum", int'(res_sum), m_sum);
        chk("rnd.res_cout", int'(res_cout), int'(m_cout));
        chk("rnd.res_id", int'(res_id), int'(m_id));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
